// File: rtl/stencil_pkg.sv
// Shared types for the stencil filter.
//   filter_mode_t   : kernel select carried on the mode input.
//   stencil_state_t : row-walk FSM states.
//   EXT_W           : headroom bits added to a pixel for kernel arithmetic.
package stencil_pkg;

  typedef enum logic [1:0] {
    PASS    = 2'b00,
    GAUSS   = 2'b01,
    SOBEL   = 2'b10,
    SHARPEN = 2'b11
  } filter_mode_t;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    HOLD  = 2'b01,
    FLUSH = 2'b10
  } stencil_state_t;

  // Sign bit plus enough growth for 16x a full-scale pixel.
  localparam int EXT_W = 5;

endpackage

// File: rtl/stencil_filter_if.sv
// Stream interface of the stencil filter.
//   mode, in_valid/in_ready/in_last, top/mid/bot_pix : input column group
//   out_valid/out_ready, pixel_out                  : filtered result
//   master : producer/consumer side (bench), slave : filter side.
interface stencil_filter_if #(
  parameter int PIX_W = 8,
  parameter int LANES = 4
);
  localparam int WORD_W = PIX_W * LANES;

  logic [1:0]        mode;
  logic              in_valid;
  logic              in_ready;
  logic              in_last;
  logic [WORD_W-1:0] top_pix;
  logic [WORD_W-1:0] mid_pix;
  logic [WORD_W-1:0] bot_pix;
  logic              out_valid;
  logic              out_ready;
  logic [WORD_W-1:0] pixel_out;

  modport master (
    output mode, in_valid, in_last, top_pix, mid_pix, bot_pix, out_ready,
    input  in_ready, out_valid, pixel_out
  );

  modport slave (
    input  mode, in_valid, in_last, top_pix, mid_pix, bot_pix, out_ready,
    output in_ready, out_valid, pixel_out
  );
endinterface

// File: rtl/stencil_lane.sv
// One output pixel from a 3x3 window (t/m/b rows, l/c/r columns).
// Purely combinational.
//   mode       : kernel select
//   tl..br     : nine unsigned window pixels
//   pix        : filtered, saturated pixel
module stencil_lane
  import stencil_pkg::*;
#(
  parameter int PIX_W = 8
) (
  input  filter_mode_t     mode,
  input  logic [PIX_W-1:0] tl, tc, tr,
  input  logic [PIX_W-1:0] ml, mc, mr,
  input  logic [PIX_W-1:0] bl, bc, br,
  output logic [PIX_W-1:0] pix
);
  localparam int IW = PIX_W + EXT_W;
  localparam logic signed [IW-1:0] PMAX = $signed({{EXT_W{1'b0}}, {PIX_W{1'b1}}});

  function automatic logic signed [IW-1:0] ext(input logic [PIX_W-1:0] p);
    return $signed({{EXT_W{1'b0}}, p});
  endfunction

  logic signed [IW-1:0] gsum, gx, gy, ax, ay, mag, shp;

  always_comb begin
    gsum = ext(tl) + (ext(tc) <<< 1) + ext(tr)
         + (ext(ml) <<< 1) + (ext(mc) <<< 2) + (ext(mr) <<< 1)
         + ext(bl) + (ext(bc) <<< 1) + ext(br);
    gx   = (ext(tr) + (ext(mr) <<< 1) + ext(br))
         - (ext(tl) + (ext(ml) <<< 1) + ext(bl));
    gy   = (ext(bl) + (ext(bc) <<< 1) + ext(br))
         - (ext(tl) + (ext(tc) <<< 1) + ext(tr));
    ax   = (gx < 0) ? -gx : gx;
    ay   = (gy < 0) ? -gy : gy;
    mag  = ax + ay;
    shp  = (ext(mc) <<< 2) + ext(mc) - ext(tc) - ext(bc) - ext(ml) - ext(mr);

    pix = mc;
    case (mode)
      PASS:    pix = mc;
      // gsum is never negative; dropping 4 LSBs is the truncating /16
      GAUSS:   pix = gsum[PIX_W+3:4];
      SOBEL:   pix = (mag > PMAX) ? {PIX_W{1'b1}} : mag[PIX_W-1:0];
      SHARPEN: begin
        if (shp < 0)         pix = '0;
        else if (shp > PMAX) pix = {PIX_W{1'b1}};
        else                 pix = shp[PIX_W-1:0];
      end
      default: pix = mc;
    endcase
  end
endmodule

// File: rtl/stencil_filter.sv
// Row-streaming 3x3 stencil filter. Each accepted word carries LANES
// adjacent columns of rows y-1/y/y+1; the filtered row-y word for a held
// center is emitted once its right neighbour column is known (next word,
// or edge replicate at end of row).
//   clk, rst_n : clock, async active-low reset
//   bus        : stencil_filter_if slave (input stream + output stream)
module stencil_filter
  import stencil_pkg::*;
#(
  parameter int PIX_W = 8,
  parameter int LANES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  stencil_filter_if.slave   bus
);
  typedef logic [LANES-1:0][PIX_W-1:0] word_t;

  stencil_state_t state, nstate;
  filter_mode_t   mode_q;

  word_t ctr_t, ctr_m, ctr_b;
  word_t in_t, in_m, in_b;
  word_t lane_pix;
  word_t pix_q;
  logic  out_vld_q;

  // Column left of lane 0 / right of lane LANES-1
  logic [PIX_W-1:0] lft_t, lft_m, lft_b;
  logic [PIX_W-1:0] rgt_t, rgt_m, rgt_b;

  logic out_free, accept, emit;

  assign in_t = bus.top_pix;
  assign in_m = bus.mid_pix;
  assign in_b = bus.bot_pix;

  assign out_free     = !out_vld_q || bus.out_ready;
  assign bus.in_ready = (state != FLUSH) && out_free;
  assign accept       = bus.in_valid && bus.in_ready;

  assign bus.out_valid = out_vld_q;
  assign bus.pixel_out = pix_q;

  // In HOLD the right neighbour is the incoming word's lane 0; in FLUSH the
  // row has ended, so the last center column is replicated.
  always_comb begin
    if (state == FLUSH) begin
      rgt_t = ctr_t[LANES-1];
      rgt_m = ctr_m[LANES-1];
      rgt_b = ctr_b[LANES-1];
    end else begin
      rgt_t = in_t[0];
      rgt_m = in_m[0];
      rgt_b = in_b[0];
    end
  end

  always_comb begin
    nstate = state;
    emit   = 1'b0;
    case (state)
      EMPTY: if (accept) nstate = bus.in_last ? FLUSH : HOLD;
      HOLD: if (accept) begin
        emit   = 1'b1;
        nstate = bus.in_last ? FLUSH : HOLD;
      end
      FLUSH: if (out_free) begin
        emit   = 1'b1;
        nstate = EMPTY;
      end
      default: nstate = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else        state <= nstate;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= PASS;
      ctr_t  <= '0;
      ctr_m  <= '0;
      ctr_b  <= '0;
      lft_t  <= '0;
      lft_m  <= '0;
      lft_b  <= '0;
    end else if (accept) begin
      ctr_t <= in_t;
      ctr_m <= in_m;
      ctr_b <= in_b;
      if (state == EMPTY) begin
        // New row: mode is frozen here and the left edge is replicated
        mode_q <= filter_mode_t'(bus.mode);
        lft_t  <= in_t[0];
        lft_m  <= in_m[0];
        lft_b  <= in_b[0];
      end else begin
        lft_t <= ctr_t[LANES-1];
        lft_m <= ctr_m[LANES-1];
        lft_b <= ctr_b[LANES-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld_q <= 1'b0;
      pix_q     <= '0;
    end else if (emit) begin
      out_vld_q <= 1'b1;
      pix_q     <= lane_pix;
    end else if (bus.out_ready) begin
      out_vld_q <= 1'b0;
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [PIX_W-1:0] l_t, l_m, l_b, r_t, r_m, r_b;

    if (i == 0) begin : g_left_edge
      assign l_t = lft_t;
      assign l_m = lft_m;
      assign l_b = lft_b;
    end else begin : g_left_in
      assign l_t = ctr_t[i-1];
      assign l_m = ctr_m[i-1];
      assign l_b = ctr_b[i-1];
    end

    if (i == LANES-1) begin : g_right_edge
      assign r_t = rgt_t;
      assign r_m = rgt_m;
      assign r_b = rgt_b;
    end else begin : g_right_in
      assign r_t = ctr_t[i+1];
      assign r_m = ctr_m[i+1];
      assign r_b = ctr_b[i+1];
    end

    stencil_lane #(.PIX_W(PIX_W)) u_lane (
      .mode (mode_q),
      .tl   (l_t), .tc (ctr_t[i]), .tr (r_t),
      .ml   (l_m), .mc (ctr_m[i]), .mr (r_m),
      .bl   (l_b), .bc (ctr_b[i]), .br (r_b),
      .pix  (lane_pix[i])
    );
  end
endmodule

// File: tb/tb_stencil_filter.sv
module tb_stencil_filter;
  logic clk;
  logic rst_n;

  stencil_filter_if #(.PIX_W(8), .LANES(4)) bus ();

  stencil_filter #(.PIX_W(8), .LANES(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  logic [31:0] got[$];

  // Record every word the sink will take on the coming rising edge
  always @(negedge clk)
    if (bus.out_valid && bus.out_ready) got.push_back(bus.pixel_out);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic put(input logic [1:0] m, input logic [31:0] t, input logic [31:0] mi,
                     input logic [31:0] b, input logic last);
    int n;
    bus.mode     = m;
    bus.top_pix  = t;
    bus.mid_pix  = mi;
    bus.bot_pix  = b;
    bus.in_last  = last;
    bus.in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("accept_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic drain();
    repeat (8) @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic chk_got(input string tag, input logic [31:0] exp[$]);
    chk({tag, "_count"}, 64'(got.size()), 64'(exp.size()));
    for (int i = 0; i < exp.size(); i++)
      chk($sformatf("%s_%0d", tag, i), (i < got.size()) ? 64'(got[i]) : 64'hx, 64'(exp[i]));
  endtask

  logic [31:0] exp_q[$];

  initial begin
    rst_n         = 1'b0;
    bus.mode      = 2'b00;
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.top_pix   = '0;
    bus.mid_pix   = '0;
    bus.bot_pix   = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_pixel_out", 64'(bus.pixel_out), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;

    // pass, two-word row, exact latency
    got.delete();
    put(2'b00, 32'h04030201, 32'h04030201, 32'h04030201, 1'b0);
    put(2'b00, 32'h08070605, 32'h08070605, 32'h08070605, 1'b1);
    @(negedge clk);
    chk("pass_w0_valid", 64'(bus.out_valid), 64'd1);
    chk("pass_w0_data",  64'(bus.pixel_out), 64'h04030201);
    chk("flush_in_ready", 64'(bus.in_ready), 64'd0);
    @(negedge clk);
    chk("pass_w1_valid", 64'(bus.out_valid), 64'd1);
    chk("pass_w1_data",  64'(bus.pixel_out), 64'h08070605);
    @(negedge clk);
    chk("pass_idle_valid", 64'(bus.out_valid), 64'd0);
    @(posedge clk); #1;

    // gauss, flat 0x80, three words
    got.delete();
    put(2'b01, 32'h80808080, 32'h80808080, 32'h80808080, 1'b0);
    put(2'b01, 32'h80808080, 32'h80808080, 32'h80808080, 1'b0);
    put(2'b01, 32'h80808080, 32'h80808080, 32'h80808080, 1'b1);
    drain();
    exp_q = '{32'h80808080, 32'h80808080, 32'h80808080};
    chk_got("gauss", exp_q);

    // sobel, single word, both edges replicated
    got.delete();
    put(2'b10, 32'hFF000000, 32'hFF000000, 32'hFF000000, 1'b1);
    drain();
    exp_q = '{32'hFFFF0000};
    chk_got("sobel", exp_q);

    // sharpen, negative clamp
    got.delete();
    put(2'b11, 32'hFFFFFFFF, 32'h10101010, 32'hFFFFFFFF, 1'b1);
    drain();
    exp_q = '{32'h00000000};
    chk_got("sharpen", exp_q);

    // mode latched at row start: second word's PASS is ignored
    got.delete();
    put(2'b01, 32'h0, 32'h40404040, 32'h0, 1'b0);
    put(2'b00, 32'h0, 32'h40404040, 32'h0, 1'b1);
    drain();
    exp_q = '{32'h20202020, 32'h20202020};
    chk_got("mode_latch", exp_q);

    // backpressure: sink stalls three cycles
    got.delete();
    bus.out_ready = 1'b0;
    put(2'b00, 32'hA1A2A3A4, 32'hA1A2A3A4, 32'hA1A2A3A4, 1'b0);
    put(2'b00, 32'hB1B2B3B4, 32'hB1B2B3B4, 32'hB1B2B3B4, 1'b0);
    bus.mode = 2'b00; bus.top_pix = 32'hC1C2C3C4; bus.mid_pix = 32'hC1C2C3C4;
    bus.bot_pix = 32'hC1C2C3C4; bus.in_last = 1'b1; bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("stall_valid_%0d", i), 64'(bus.out_valid), 64'd1);
      chk($sformatf("stall_data_%0d", i),  64'(bus.pixel_out), 64'hA1A2A3A4);
      chk($sformatf("stall_ready_%0d", i), 64'(bus.in_ready), 64'd0);
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    put(2'b00, 32'hC1C2C3C4, 32'hC1C2C3C4, 32'hC1C2C3C4, 1'b1);
    drain();
    exp_q = '{32'hA1A2A3A4, 32'hB1B2B3B4, 32'hC1C2C3C4};
    chk_got("stall", exp_q);

    // reset while holding a word with a result pending
    got.delete();
    put(2'b00, 32'h11111111, 32'h11111111, 32'h11111111, 1'b0);
    put(2'b00, 32'h22222222, 32'h22222222, 32'h22222222, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("midrst_pixel_out", 64'(bus.pixel_out), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("midrst_in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;
    put(2'b01, 32'h0, 32'h00000040, 32'h0, 1'b1);
    drain();
    exp_q = '{32'h00000818};
    chk_got("post_rst", exp_q);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule
